// File: rtl/svfloat_div_stream_pkg.sv
// Shared float type and sizing helper for the streaming divider wrapper.
package svfloat_div_stream_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/svfloat_div_stream_if.sv
// Upstream operand / downstream result handshake bundle for svfloat_div_stream.
interface svfloat_div_stream_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_lhs;
  logic [W-1:0] in_rhs;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;

  modport master (
    output in_valid, in_lhs, in_rhs, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_lhs, in_rhs, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/svfloat_sync_fifo.sv
// Synchronous FIFO with a separate occupancy count so full and empty never alias.
module svfloat_sync_fifo
  import svfloat_div_stream_pkg::*;
#(
  parameter type T     = float32,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/svfloat_div_stream.sv
// Valid/ready wrapper around a fixed-latency, stall-free divider: operand registers,
// in-flight tracking, and a credit-protected result FIFO.
module svfloat_div_stream
  import svfloat_div_stream_pkg::*;
#(
  parameter type float       = float32,
  parameter int  div_latency = 0,
  parameter int  fifo_depth  = 4,
  localparam int VW          = div_latency + 1,
  localparam int OW          = cnt_w(fifo_depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  svfloat_div_stream_if.slave  bus,
  output float                 div_lhs,
  output float                 div_rhs,
  input  float                 div_res,
  output logic [OW-1:0]        occupancy
);

  float          lhs_q, lhs_d;
  float          rhs_q, rhs_d;
  logic [VW-1:0] vld_q, vld_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          rdy_en_q, rdy_en_d;
  logic          accept;
  logic          pop;
  logic          push;
  logic [OW-1:0] fifo_count;
  float          fifo_rdata;

  // Occupancy counts every op from accept until pop, so the FIFO always has room
  // for everything still travelling through the divider.
  assign bus.in_ready  = rdy_en_q && (occ_q < OW'(fifo_depth));
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_res   = fifo_rdata;

  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    push     = vld_q[div_latency];
    rdy_en_d = 1'b1;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    if (accept) begin
      lhs_d = bus.in_lhs;
      rhs_d = bus.in_rhs;
    end
    vld_d = (vld_q << 1) | VW'(accept);
    occ_d = occ_q + OW'(accept) - OW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhs_q    <= '0;
      rhs_q    <= '0;
      vld_q    <= '0;
      occ_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      vld_q    <= vld_d;
      occ_q    <= occ_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  svfloat_sync_fifo #(
    .T     (float),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (div_res),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign div_lhs   = lhs_q;
  assign div_rhs   = rhs_q;
  assign occupancy = occ_q;

endmodule

// File: doc/svfloat_div_stream.md
Name: svfloat_div_stream

Overview:
- Streaming valid/ready front-end and back-end for the floating-point divider.
- Accepts operand pairs from upstream, registers them onto the divider's lhs/rhs inputs, and tracks each operation through the divider's fixed pipeline latency.
- Captures each divider result into an output FIFO and presents it to the downstream consumer.
- Lets a fixed-latency, stall-free divider sit inside a back-pressured datapath without losing results.

Parameters:
- float, svfloat::float32, floating-point type; must match the divider instance.
- div_latency, 0, divider register count (plr_pre_div + plr_post_div); legal range 0..2.
- fifo_depth, 4, output FIFO entries; power of two, >= div_latency+2.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_lhs  in  $bits(float)  dividend
- in_rhs  in  $bits(float)  divisor
- div_lhs  out  $bits(float)  to divider lhs
- div_rhs  out  $bits(float)  to divider rhs
- div_res  in  $bits(float)  from divider res
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_res  out  $bits(float)  quotient at FIFO head
- occupancy  out  $clog2(fifo_depth)+1  in-flight plus buffered operations

Behaviour:
- Reset, asynchronous on rst_n low:
  - Operand registers, valid shift register, FIFO pointers/count and storage all go to 0.
  - Outputs: div_lhs=0, div_rhs=0, out_valid=0, out_res=0, occupancy=0, in_ready=0 while rst_n low.
  - in_ready rises in the first cycle after rst_n deasserts.
- Accept: in_valid && in_ready at edge N.
  - in_lhs/in_rhs load into the operand registers, which drive div_lhs/div_rhs.
  - Operand registers hold their value until the next accept.
- Tracking: a 1-bit valid shift register of length div_latency+1.
  - Stage 0 is set at an accept edge, cleared otherwise; it advances every cycle and never stalls.
  - An op accepted at edge N reaches the last stage during the cycle after edge N+div_latency.
  - div_res is written into the FIFO at edge N+div_latency+1.
  - out_valid rises immediately after that edge: accept-to-out_valid = div_latency+1 edges.
- Back-to-back accepts: one per cycle sustained while credit allows; results leave in issue order.
- Credit rule:
  - occupancy = (set bits in the valid shift register) + FIFO count, registered.
  - in_ready = rst_n synchronised high && occupancy < fifo_depth.
  - The FIFO therefore never overflows, even with out_ready held low.
- Output:
  - out_valid = FIFO count != 0; out_res = FIFO head.
  - Pop on out_valid && out_ready.
  - out_res is stable while out_valid && !out_ready.
- Simultaneous events:
  - Accept + pop in one cycle: occupancy unchanged.
  - Capture + pop in one cycle: FIFO count unchanged; head advances correctly, including at pointer wrap.
  - FIFO empty with capture + out_ready: out_valid rises the next cycle; no fall-through.
- Wrap-around: read/write pointers wrap modulo fifo_depth. The count is kept separately, so full and empty are unambiguous.
- Reset mid-operation: all in-flight and buffered results are discarded. No result from before reset ever appears on out_res.
- No arithmetic is performed here. div_res is forwarded bit-exact, including NaN payloads, infinities and signed zeros.

Decomposition:
- svfloat package: float types only; nothing new is added.
- One sub-module: svfloat_sync_fifo.
  - Parameters: type and depth. Ports: clk, rst_n, push, pop, wdata, rdata, count.
  - Holds the storage, pointers and count.
- Credit logic, operand registers and the valid shift register stay in svfloat_div_stream.
- The bench instantiates svfloat_div with matching plr_pre_div/plr_post_div next to this block.

Test Plan:
1. div_latency=0, out_ready=1: accept lhs=0x40C00000 (6.0), rhs=0x40000000 (2.0) at edge N -> out_valid high after edge N+1 with out_res=0x40400000 (3.0).
2. div_latency=2: accepts 1.0/3.0, 1.0/0.0, 0.0/0.0 on consecutive cycles -> out_res=0x3EAAAAAB, 0x7F800000, quiet NaN, in order, on consecutive cycles starting 3 edges after the first accept.
3. fifo_depth=4, out_ready=0, in_valid held with 6 pairs -> exactly 4 accepts; in_ready low with occupancy=4. Then out_ready=1 -> the remaining 2 are accepted; all 6 results emerge in order.
4. Steady state with in_valid=1 and out_ready toggling 1/0 every cycle -> no result lost or duplicated; pointers wrap at least 3 times; output matches the reference model.
5. rst_n pulled low with 3 ops in flight and 2 buffered -> out_valid=0 and occupancy=0 immediately. After release, a fresh 9.0/3.0 produces 0x40400000 as the first output.
6. Accept and pop in the same cycle at occupancy=fifo_depth-1 -> occupancy unchanged and in_ready stays high.
